// File: rtl/hazard_ctrl_id_rr.sv
// Pipeline sequencer for the IF/ID, ID/RR and RR/EX registers: load-use bubbles,
// LM/SM slot issue, EX-redirect flush and halt freeze.
module hazard_ctrl_id_rr #(
  parameter int LU_BUBBLES = 1,
  parameter int LMSM_W     = 8,
  parameter int RW         = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RW-1:0]     id_rs_a,
  input  logic              id_rs_a_used,
  input  logic [RW-1:0]     id_rs_b,
  input  logic              id_rs_b_used,
  input  logic              id_is_lmsm,
  input  logic [LMSM_W-1:0] id_lmsm_mask,
  input  logic              rr_valid,
  input  logic [RW-1:0]     rr_rdest,
  input  logic              rr_w_reg,
  input  logic              rr_is_load,
  input  logic              ex_redirect,
  input  logic              stop_seen,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              kill_IF_ID,
  output logic              kill_ID_RR,
  output logic              kill_RR_EX,
  output logic              lmsm_active,
  output logic [RW-1:0]     lmsm_reg,
  output logic              lmsm_last,
  output logic              halted
);

  typedef enum logic [1:0] {RUN, LU, LMSM, HALT} state_t;

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [LMSM_W-1:0] mask, mask_n;
  logic [LMSM_W-1:0] cur_mask, rest;
  logic [RW-1:0]     low_idx;
  logic              hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      mask  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mask  <= mask_n;
    end
  end

  assign hazard = id_valid & rr_valid & rr_is_load & rr_w_reg &
                  ((id_rs_a_used & (id_rs_a == rr_rdest)) |
                   (id_rs_b_used & (id_rs_b == rr_rdest)));

  // The same slot logic serves the entry cycle (mask from ID) and the
  // LMSM state (latched remainder); rest is the mask with its lowest bit gone.
  always_comb begin
    cur_mask = (state == LMSM) ? mask : id_lmsm_mask;
    rest     = cur_mask & (cur_mask - LMSM_W'(1));
    low_idx  = '0;
    for (int unsigned i = LMSM_W; i > 0; i--) begin
      if (cur_mask[i-1]) low_idx = RW'(i - 1);
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mask_n      = mask;
    stall_IF    = 1'b0;
    stall_ID    = 1'b0;
    kill_IF_ID  = 1'b0;
    kill_ID_RR  = 1'b0;
    kill_RR_EX  = 1'b0;
    lmsm_active = 1'b0;
    lmsm_reg    = '0;
    lmsm_last   = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      state_n = RUN;
      cnt_n   = '0;
      mask_n  = '0;
    end else if (state == HALT) begin
      stall_IF   = 1'b1;
      kill_IF_ID = 1'b1;
      halted     = 1'b1;
    end else if (ex_redirect) begin
      kill_IF_ID = 1'b1;
      kill_ID_RR = 1'b1;
      kill_RR_EX = 1'b1;
      state_n    = RUN;
      cnt_n      = '0;
      mask_n     = '0;
    end else if (stop_seen) begin
      state_n = HALT;
    end else begin
      case (state)
        LMSM: begin
          lmsm_active = 1'b1;
          lmsm_reg    = low_idx;
          mask_n      = rest;
          if (rest == '0) begin
            lmsm_last = 1'b1;
            state_n   = RUN;
          end else begin
            stall_IF = 1'b1;
            stall_ID = 1'b1;
          end
        end
        LU: begin
          stall_IF   = 1'b1;
          stall_ID   = 1'b1;
          kill_RR_EX = 1'b1;
          cnt_n      = cnt - 2'd1;
          if (cnt == 2'd1) state_n = RUN;
        end
        default: begin
          if (hazard) begin
            stall_IF   = 1'b1;
            stall_ID   = 1'b1;
            kill_RR_EX = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_n = LU;
              cnt_n   = 2'(LU_BUBBLES - 1);
            end
          end else if (id_valid && id_is_lmsm && (id_lmsm_mask != '0)) begin
            lmsm_active = 1'b1;
            lmsm_reg    = low_idx;
            if (rest == '0) begin
              lmsm_last = 1'b1;
            end else begin
              stall_IF = 1'b1;
              stall_ID = 1'b1;
              state_n  = LMSM;
              mask_n   = rest;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_id_rr.sv
// Bench for hazard_ctrl_id_rr: two instances (1 and 2 load-use bubbles) checked
// every cycle against a slot-list model, plus directed literal checks.
module tb_hazard_ctrl_id_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs_a_used, id_rs_b_used, id_is_lmsm;
  logic [2:0] id_rs_a, id_rs_b, rr_rdest;
  logic [7:0] id_lmsm_mask;
  logic       rr_valid, rr_w_reg, rr_is_load, ex_redirect, stop_seen;

  logic       s_if1, s_id1, k_ifid1, k_idrr1, k_rrex1, act1, last1, halt1;
  logic [2:0] reg1;
  logic       s_if2, s_id2, k_ifid2, k_idrr2, k_rrex2, act2, last2, halt2;
  logic [2:0] reg2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_id_rr #(.LU_BUBBLES(1), .LMSM_W(8), .RW(3)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a),
    .id_rs_a_used(id_rs_a_used), .id_rs_b(id_rs_b), .id_rs_b_used(id_rs_b_used),
    .id_is_lmsm(id_is_lmsm), .id_lmsm_mask(id_lmsm_mask), .rr_valid(rr_valid),
    .rr_rdest(rr_rdest), .rr_w_reg(rr_w_reg), .rr_is_load(rr_is_load),
    .ex_redirect(ex_redirect), .stop_seen(stop_seen),
    .stall_IF(s_if1), .stall_ID(s_id1), .kill_IF_ID(k_ifid1), .kill_ID_RR(k_idrr1),
    .kill_RR_EX(k_rrex1), .lmsm_active(act1), .lmsm_reg(reg1), .lmsm_last(last1),
    .halted(halt1));

  hazard_ctrl_id_rr #(.LU_BUBBLES(2), .LMSM_W(8), .RW(3)) u2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a),
    .id_rs_a_used(id_rs_a_used), .id_rs_b(id_rs_b), .id_rs_b_used(id_rs_b_used),
    .id_is_lmsm(id_is_lmsm), .id_lmsm_mask(id_lmsm_mask), .rr_valid(rr_valid),
    .rr_rdest(rr_rdest), .rr_w_reg(rr_w_reg), .rr_is_load(rr_is_load),
    .ex_redirect(ex_redirect), .stop_seen(stop_seen),
    .stall_IF(s_if2), .stall_ID(s_id2), .kill_IF_ID(k_ifid2), .kill_ID_RR(k_idrr2),
    .kill_RR_EX(k_rrex2), .lmsm_active(act2), .lmsm_reg(reg2), .lmsm_last(last2),
    .halted(halt2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model state per instance: halted flag, bubbles still owed, and the list of
  // register slots of the current LM/SM with a read pointer.
  bit m_halt [2];
  int m_lu   [2];
  int m_slot [2][8];
  int m_n    [2];
  int m_h    [2];

  task automatic model(input int k, output logic [10:0] e);
    bit sif, sid, kif, kid, krr, act, lst, hlt, haz;
    int r, n, bub;
    sif = 0; sid = 0; kif = 0; kid = 0; krr = 0; act = 0; lst = 0; hlt = 0; r = 0;
    bub = (k == 0) ? 1 : 2;
    haz = id_valid && rr_valid && rr_is_load && rr_w_reg &&
          ((id_rs_a_used && id_rs_a == rr_rdest) || (id_rs_b_used && id_rs_b == rr_rdest));
    if (reset) begin
      m_halt[k] = 0; m_lu[k] = 0; m_n[k] = 0; m_h[k] = 0;
    end else if (m_halt[k]) begin
      sif = 1; kif = 1; hlt = 1;
    end else if (ex_redirect) begin
      kif = 1; kid = 1; krr = 1;
      m_lu[k] = 0; m_n[k] = 0; m_h[k] = 0;
    end else if (stop_seen) begin
      m_halt[k] = 1;
    end else if (m_h[k] < m_n[k]) begin
      act = 1; r = m_slot[k][m_h[k]];
      lst = (m_h[k] + 1 == m_n[k]);
      sif = !lst; sid = !lst;
      m_h[k]++;
    end else if (m_lu[k] > 0) begin
      sif = 1; sid = 1; krr = 1;
      m_lu[k]--;
    end else if (haz) begin
      sif = 1; sid = 1; krr = 1;
      m_lu[k] = bub - 1;
    end else if (id_valid && id_is_lmsm && id_lmsm_mask != 8'h00) begin
      n = 0;
      for (int i = 0; i < 8; i++) if (id_lmsm_mask[i]) begin m_slot[k][n] = i; n++; end
      m_n[k] = n; m_h[k] = 1;
      act = 1; r = m_slot[k][0];
      lst = (n == 1);
      sif = !lst; sid = !lst;
    end
    e = {sif, sid, kif, kid, krr, act, lst, hlt, 3'(r)};
  endtask

  always @(negedge clk) begin
    logic [10:0] e0, e1;
    model(0, e0);
    check("u1_outputs", {21'd0, s_if1, s_id1, k_ifid1, k_idrr1, k_rrex1, act1, last1, halt1, reg1}, {21'd0, e0});
    model(1, e1);
    check("u2_outputs", {21'd0, s_if2, s_id2, k_ifid2, k_idrr2, k_rrex2, act2, last2, halt2, reg2}, {21'd0, e1});
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_a = 0; id_rs_a_used = 0; id_rs_b = 0; id_rs_b_used = 0;
    id_is_lmsm = 0; id_lmsm_mask = 0; rr_valid = 0; rr_rdest = 0; rr_w_reg = 0;
    rr_is_load = 0; ex_redirect = 0; stop_seen = 0;
  endtask

  task automatic set_hazard();
    rr_valid = 1; rr_is_load = 1; rr_w_reg = 1; rr_rdest = 3;
    id_valid = 1; id_rs_a = 3; id_rs_a_used = 1;
  endtask

  task automatic set_lm(input logic [7:0] m);
    idle();
    id_valid = 1; id_is_lmsm = 1; id_lmsm_mask = m;
  endtask

  initial begin
    reset = 1; idle();
    go(); go();
    reset = 0;
    #1 check("reset_outputs_u1", {s_if1, s_id1, k_ifid1, k_idrr1, k_rrex1, act1, last1, halt1, reg1}, 0);
    go();

    // load-use: LW r3 in RR, ADD reading r3 in ID
    set_hazard();
    #1 check("lu_c0_u1_stall_IF", s_if1, 1);
    check("lu_c0_u2_kill_RR_EX", k_rrex2, 1);
    go(); rr_valid = 0;
    #1 check("lu_c1_u1_stall_IF", s_if1, 0);
    check("lu_c1_u2_stall_ID", s_id2, 1);
    go();
    #1 check("lu_c2_u2_stall_IF", s_if2, 0);
    go();
    set_hazard(); id_rs_a_used = 0; id_rs_b = 5; id_rs_b_used = 1;
    #1 check("unused_src_no_bubble", k_rrex1, 0);
    go(); set_hazard(); id_rs_a = 6; id_rs_b = 3; id_rs_b_used = 1;
    go(); idle();
    go();

    // LM 1010_0101 -> slots 0,2,5,7
    set_lm(8'b1010_0101);
    #1 check("lm_slot0_reg", reg1, 0);
    check("lm_slot0_stall", s_if1, 1);
    go(); idle();
    #1 check("lm_slot1_reg", reg1, 2);
    go();
    #1 check("lm_slot2_reg", reg1, 5);
    check("lm_slot2_stall", s_id1, 1);
    go();
    #1 check("lm_slot3_reg", reg1, 7);
    check("lm_slot3_last", last1, 1);
    check("lm_slot3_nostall", s_if1, 0);
    go();
    #1 check("lm_done_active", act1, 0);
    go();

    // redirect in the second LMSM cycle
    set_lm(8'hFF);
    go(); idle();
    go(); ex_redirect = 1;
    #1 check("redir_kill_RR_EX", k_rrex1, 1);
    check("redir_kill_IF_ID", k_ifid2, 1);
    check("redir_active", act1, 0);
    go(); ex_redirect = 0;
    #1 check("post_redir_active", act1, 0);
    go();

    // reset for 2 cycles mid-LMSM
    set_lm(8'hFF);
    go(); idle();
    go(); reset = 1;
    go(); go(); reset = 0;
    #1 check("post_reset_active", act2, 0);
    check("post_reset_stall", s_if2, 0);
    go();

    // single-bit and empty masks
    set_lm(8'h10);
    #1 check("one_bit_reg", reg1, 4);
    check("one_bit_last", last1, 1);
    check("one_bit_nostall", s_if1, 0);
    go(); idle();
    #1 check("one_bit_after", act1, 0);
    go(); set_lm(8'h00);
    #1 check("zero_mask_active", act1, 0);
    go(); idle();
    go();

    // redirect during the second bubble of u2
    set_hazard();
    go(); idle(); ex_redirect = 1;
    go(); idle();
    go();

    // stop_seen with a concurrent load-use hazard
    set_hazard(); stop_seen = 1;
    #1 check("stop_cycle_halted", halt1, 0);
    go(); idle();
    for (int i = 0; i < 10; i++) begin
      ex_redirect = (i % 2 == 1);
      if (i == 4) set_lm(8'h0F);
      if (i == 6) set_hazard();
      #1 check("halt_halted", halt1, 1);
      check("halt_stall_IF", s_if2, 1);
      check("halt_kill_IF_ID", k_ifid1, 1);
      go(); idle();
    end
    reset = 1;
    go(); reset = 0;
    #1 check("unhalt", halt2, 0);
    go(); go();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
